// File: rtl/shift_sequencer.sv
// Multi-cycle LSR/LSL/ASR controller around an 8-bit right-only barrel shifter.
// Amounts above 7 re-circulate the shifter output; LSL/ASR use reverse/invert.
module shift_sequencer #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [W-1:0]  req_data,
  input  logic [AW-1:0] req_amt,
  input  logic [1:0]    req_op,
  output logic [W-1:0]  sh_ym,
  output logic [2:0]    sh_k,
  input  logic [W-1:0]  sh_q,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          neg_q, neg_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [W-1:0]  work_q, work_d;
  logic [W-1:0]  ym_hold_q, ym_hold_d;
  logic [2:0]    k_hold_q, k_hold_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_data_q, res_data_d;

  logic [2:0]    k_cur;
  logic          last_pass;
  logic [W-1:0]  pre_val;
  logic [W-1:0]  post_val;

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  always_comb begin
    k_cur     = (rem_q > AW'(7)) ? 3'd7 : rem_q[2:0];
    last_pass = (rem_q <= AW'(7));

    pre_val = req_data;
    if (req_op == OP_LSL) pre_val = rev(req_data);
    if (req_op == OP_ASR && req_data[W-1]) pre_val = ~req_data;

    post_val = sh_q;
    if (op_q == OP_LSL) post_val = rev(sh_q);
    if (neg_q) post_val = ~post_val;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    rem_d       = rem_q;
    work_d      = work_q;
    ym_hold_d   = ym_hold_q;
    k_hold_d    = k_hold_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          rem_d   = req_amt;
          neg_d   = (req_op == OP_ASR) && req_data[W-1];
          work_d  = pre_val;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d    = sh_q;
        rem_d     = rem_q - AW'(k_cur);
        ym_hold_d = work_q;
        k_hold_d  = k_cur;
        if (last_pass) begin
          res_data_d  = post_val;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      neg_q       <= 1'b0;
      rem_q       <= '0;
      work_q      <= '0;
      ym_hold_q   <= '0;
      k_hold_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      rem_q       <= rem_d;
      work_q      <= work_d;
      ym_hold_q   <= ym_hold_d;
      k_hold_q    <= k_hold_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Shifter inputs are live only in SHIFT; otherwise show the last pass.
  assign sh_ym     = (state_q == SHIFT) ? work_q : ym_hold_q;
  assign sh_k      = (state_q == SHIFT) ? k_cur : k_hold_q;
  assign req_ready = (state_q == IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural right barrel shifter.
// Uses immediate assertions; prints one summary line.
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [3:0] req_amt;
  logic [1:0] req_op;
  logic [7:0] sh_ym;
  logic [2:0] sh_k;
  logic [7:0] sh_q;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.W(8), .AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_amt  (req_amt),
    .req_op   (req_op),
    .sh_ym    (sh_ym),
    .sh_k     (sh_k),
    .sh_q     (sh_q),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data)
  );

  assign sh_q = sh_ym >> sh_k;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request with res_ready=1 and follow it through every pass.
  task automatic run(input string tag, input logic [7:0] d,
                     input logic [3:0] amt, input logic [1:0] op,
                     input logic [7:0] exp_ym, input logic [7:0] exp);
    int rem;
    int k;
    int passes;
    passes = (amt <= 7) ? 1 : (amt <= 14) ? 2 : 3;
    rem = amt;
    chk({tag, " ready"}, 16'(req_ready), 16'd1);
    req_data  = d;
    req_amt   = amt;
    req_op    = op;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_data  = ~d;
    req_amt   = 4'd0;
    req_op    = 2'b00;
    chk({tag, " ym"}, 16'(sh_ym), 16'(exp_ym));
    for (int p = 0; p < passes; p++) begin
      k = (rem > 7) ? 7 : rem;
      chk({tag, " k"}, 16'(sh_k), 16'(k));
      chk({tag, " busy"}, 16'(res_valid), 16'd0);
      rem = rem - k;
      tick();
    end
    chk({tag, " valid"}, 16'(res_valid), 16'd1);
    chk({tag, " data"}, 16'(res_data), 16'(exp));
    chk({tag, " rdy_done"}, 16'(req_ready), 16'd0);
    tick();
    chk({tag, " idle"}, 16'(req_ready), 16'd1);
    chk({tag, " vlow"}, 16'(res_valid), 16'd0);
  endtask

  logic [7:0] bd [4];
  logic [3:0] ba [4];
  logic [1:0] bo [4];
  logic [7:0] be [4];

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_data  = 8'h00;
    req_amt   = 4'd0;
    req_op    = 2'b00;
    res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst ready", 16'(req_ready), 16'd1);
    chk("rst valid", 16'(res_valid), 16'd0);
    chk("rst data", 16'(res_data), 16'h00);
    chk("rst ym", 16'(sh_ym), 16'h00);
    chk("rst k", 16'(sh_k), 16'd0);

    run("lsr_b4_3", 8'hB4, 4'd3, 2'b00, 8'hB4, 8'h16);
    run("lsl_81_1", 8'h81, 4'd1, 2'b01, 8'h81, 8'h02);
    run("lsl_0f_4", 8'h0F, 4'd4, 2'b01, 8'hF0, 8'hF0);
    run("asr_90_2", 8'h90, 4'd2, 2'b10, 8'h6F, 8'hE4);
    run("asr_70_2", 8'h70, 4'd2, 2'b10, 8'h70, 8'h1C);
    run("lsr_ff_15", 8'hFF, 4'd15, 2'b00, 8'hFF, 8'h00);
    run("asr_80_12", 8'h80, 4'd12, 2'b10, 8'h7F, 8'hFF);
    run("amt0_a5", 8'hA5, 4'd0, 2'b00, 8'hA5, 8'hA5);
    run("lsl_12_9", 8'h12, 4'd9, 2'b01, 8'h48, 8'h00);
    run("asr_40_7", 8'h40, 4'd7, 2'b10, 8'h40, 8'h00);
    run("asr_c3_7", 8'hC3, 4'd7, 2'b10, 8'h3C, 8'hFF);
    run("rsv_f0_4", 8'hF0, 4'd4, 2'b11, 8'hF0, 8'h0F);

    // Backpressure: result held while a new request is presented.
    res_ready = 1'b0;
    req_data  = 8'h3C;
    req_amt   = 4'd2;
    req_op    = 2'b00;
    req_valid = 1'b1;
    tick();
    req_data = 8'hEE;
    req_amt  = 4'd1;
    tick();
    chk("bp valid", 16'(res_valid), 16'd1);
    chk("bp data", 16'(res_data), 16'h0F);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp hold valid", 16'(res_valid), 16'd1);
      chk("bp hold data", 16'(res_data), 16'h0F);
      chk("bp ready", 16'(req_ready), 16'd0);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("bp release valid", 16'(res_valid), 16'd0);
    chk("bp release ready", 16'(req_ready), 16'd1);
    tick();
    chk("bp no stale", 16'(res_valid), 16'd0);

    // Back-to-back with req_valid held high throughout.
    bd[0] = 8'h55; ba[0] = 4'd1; bo[0] = 2'b00; be[0] = 8'h2A;
    bd[1] = 8'h01; ba[1] = 4'd7; bo[1] = 2'b01; be[1] = 8'h80;
    bd[2] = 8'hC0; ba[2] = 4'd9; bo[2] = 2'b10; be[2] = 8'hFF;
    bd[3] = 8'h7F; ba[3] = 4'd3; bo[3] = 2'b11; be[3] = 8'h0F;
    req_data  = bd[0];
    req_amt   = ba[0];
    req_op    = bo[0];
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int n;
      chk("b2b ready", 16'(req_ready), 16'd1);
      tick();
      if (i < 3) begin
        req_data = bd[i+1];
        req_amt  = ba[i+1];
        req_op   = bo[i+1];
      end else begin
        req_valid = 1'b0;
        req_data  = 8'h00;
      end
      n = 0;
      while (!res_valid && n < 8) begin
        chk("b2b busy ready", 16'(req_ready), 16'd0);
        tick();
        n++;
      end
      chk("b2b timeout", 16'(res_valid), 16'd1);
      chk("b2b data", 16'(res_data), 16'(be[i]));
      chk("b2b done ready", 16'(req_ready), 16'd0);
      tick();
    end
    chk("b2b end valid", 16'(res_valid), 16'd0);

    // Reset during the second pass of a 15-bit shift.
    req_data  = 8'hFF;
    req_amt   = 4'd15;
    req_op    = 2'b00;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rst2 pass2 k", 16'(sh_k), 16'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2 ready", 16'(req_ready), 16'd1);
    chk("rst2 valid", 16'(res_valid), 16'd0);
    chk("rst2 data", 16'(res_data), 16'h00);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst2 no stale", 16'(res_valid), 16'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
